ex_alu_stage: RTL

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

---
 rtl/ex_alu_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: single-register execute stage of the integer pipeline.
// Computes one ALU operation per accepted input and holds the result in an
// output register with a valid/ready handshake toward writeback.
//
// Ports:
//   clk, rst              system clock (rising edge), async active-high reset
//   in_valid / in_ready   decode handshake; in_ready = !flush && (!out_valid || out_ready)
//   in_op                 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND
//   in_rs1, in_rs2, in_imm, in_use_imm   operand A, register/immediate operand B
//   in_rd                 destination register index
//   flush                 drops the held result and blocks new input
//   out_valid / out_ready writeback handshake
//   out_result, out_rd, out_wr_en, out_illegal   registered result fields
//   retired_count         number of results consumed by writeback (wraps)
module ex_alu_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wr_en,
  output logic        out_illegal,
  output logic [31:0] retired_count
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_wr_en_q, out_wr_en_d;
  logic        out_illegal_q, out_illegal_d;
  logic [31:0] retired_count_q, retired_count_d;

  logic [31:0] op_b;
  logic [31:0] shamt;
  logic [31:0] alu_res;
  logic        alu_illegal;
  logic        transfer;
  logic        consume;

  // Only the low five bits of operand B select the shift distance.
  assign op_b  = in_use_imm ? in_imm : in_rs2;
  assign shamt = {27'd0, op_b[4:0]};

  always_comb begin
    alu_res     = 32'd0;
    alu_illegal = 1'b0;
    case (in_op)
      OP_ADD:  alu_res = in_rs1 + op_b;
      OP_SUB:  alu_res = in_rs1 - op_b;
      OP_SLL:  alu_res = in_rs1 << shamt;
      OP_SLT:  alu_res = {31'd0, ($signed(in_rs1) < $signed(op_b))};
      OP_SLTU: alu_res = {31'd0, (in_rs1 < op_b)};
      OP_XOR:  alu_res = in_rs1 ^ op_b;
      OP_SRL:  alu_res = in_rs1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_rs1) >>> shamt);
      OP_OR:   alu_res = in_rs1 | op_b;
      OP_AND:  alu_res = in_rs1 & op_b;
      default: alu_illegal = 1'b1;
    endcase
  end

  // Flush takes priority: no new input is accepted while the stage is being cleared.
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign transfer = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready && !flush;

  always_comb begin
    out_valid_d     = out_valid_q;
    out_result_d    = out_result_q;
    out_rd_d        = out_rd_q;
    out_wr_en_d     = out_wr_en_q;
    out_illegal_d   = out_illegal_q;
    retired_count_d = retired_count_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (transfer) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (transfer) begin
      out_result_d  = alu_res;
      out_rd_d      = in_rd;
      out_wr_en_d   = !alu_illegal && (in_rd != 5'd0);
      out_illegal_d = alu_illegal;
    end

    if (consume) begin
      retired_count_d = retired_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      out_result_q    <= 32'd0;
      out_rd_q        <= 5'd0;
      out_wr_en_q     <= 1'b0;
      out_illegal_q   <= 1'b0;
      retired_count_q <= 32'd0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_result_q    <= out_result_d;
      out_rd_q        <= out_rd_d;
      out_wr_en_q     <= out_wr_en_d;
      out_illegal_q   <= out_illegal_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_rd        = out_rd_q;
  assign out_wr_en     = out_wr_en_q;
  assign out_illegal   = out_illegal_q;
  assign retired_count = retired_count_q;

endmodule
